rapid_mem_arbiter: RTL and testbench
====================================

RAPID_MEM_ARBITER -- requirements
Module: rapid_mem_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data/address width.
REQ-002 Parameter TIMEOUT, default 255, max BUSY cycles waiting for ram_ack (range 1..255, 8-bit counter).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1  instruction-fetch read request, held until if_ack.
REQ-006 if_addr  in  XLEN  fetch address.
REQ-007 if_rdata  out  XLEN  fetch read data, valid when if_ack=1.
REQ-008 if_ack  out  1  one-cycle fetch completion pulse.
REQ-009 dm_req  in  1  data-memory request, held until dm_ack.
REQ-010 dm_we  in  1  1=write, 0=read.
REQ-011 dm_addr  in  XLEN  data address.
REQ-012 dm_wdata  in  XLEN  store data.
REQ-013 dm_rdata  out  XLEN  load data, valid when dm_ack=1 and the access was a read.
REQ-014 dm_ack  out  1  one-cycle data completion pulse.
REQ-015 err  out  1  high with if_ack/dm_ack when the access timed out.
REQ-016 ram_req  out  1  shared RAM port request, registered.
REQ-017 ram_we / ram_addr / ram_wdata  out  1/XLEN/XLEN  shared RAM command, registered.
REQ-018 ram_rdata  in  XLEN  RAM read data, sampled when ram_ack=1.
REQ-019 ram_ack  in  1  RAM completion, one cycle.

Function
REQ-020 States: IDLE, BUSY, RESP; a single owner register (IF or DM) records the active requester.
REQ-021 IDLE, only one req high: that requester is granted; next state BUSY.
REQ-022 IDLE, both reqs high: the requester not served last wins; last_served resets to IF, so DM wins the first tie.
REQ-023 On grant, the granted requester's address, we (forced 0 for IF), and wdata are latched onto ram_* at the same edge; ram_req=1 throughout BUSY.
REQ-024 ram_we/ram_addr/ram_wdata SHALL stay stable while ram_req=1.
REQ-025 BUSY, ram_ack=1: capture ram_rdata into the owner's rdata (DM writes leave dm_rdata unchanged); ram_req drops; next state RESP.
REQ-026 BUSY counter counts from 0 each BUSY entry; if it reaches TIMEOUT with ram_ack=0, next state RESP with err=1, owner rdata=0, ram_req drops.
REQ-027 RESP lasts exactly one cycle: owner's ack=1, err as determined, last_served=owner; next state IDLE.
REQ-028 A requester deasserts req or presents a new request in the cycle after its ack; a req still high in IDLE is a new request (back-to-back allowed).
REQ-029 Latency: req sampled at edge N -> ram_req high from cycle N+1; ram_ack at cycle M -> ack at cycle M+1; minimum 2 cycles req-to-ack.
REQ-030 ram_ack outside BUSY is ignored.
REQ-031 A req arriving during BUSY/RESP of the other requester waits; it is granted in the next IDLE (fairness per REQ-022).
REQ-032 if_ack and dm_ack are never high together; err=0 whenever neither ack is high.
REQ-033 Requests are not queued; arbitration looks only at live req levels in IDLE.

Reset
REQ-034 On reset: state=IDLE, owner=IF, last_served=IF, counter=0, ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0, if_ack=0, dm_ack=0, err=0, if_rdata=0, dm_rdata=0.
REQ-035 Reset during BUSY/RESP aborts: ram_req=0 and no ack pulse after the reset edge; a late ram_ack is ignored.

Verification
REQ-036 if_req=1, if_addr=0x100; ram_ack in the 1st BUSY cycle with ram_rdata=0x00000013 -> ram_addr=0x100, ram_we=0; if_ack=1 with if_rdata=0x13, err=0, 2 cycles after req.
REQ-037 if_req and dm_req both high from reset (dm_we=1, dm_addr=0x2000, dm_wdata=0xDEADBEEF) -> DM served first (ram_we=1, ram_wdata=0xDEADBEEF), then IF; dm_rdata unchanged (0).
REQ-038 Both reqs held continuously across 4 transactions -> grants alternate DM, IF, DM, IF; never two acks in one cycle.
REQ-039 TIMEOUT=4, dm read, ram_ack never asserted -> ram_req high exactly 4 cycles, then dm_ack=1, err=1, dm_rdata=0; following IF access completes normally with err=0.
REQ-040 reset asserted in 2nd BUSY cycle, ram_ack pulsed in the following cycle -> ram_req=0, no if_ack/dm_ack, state IDLE, all outputs at reset values.
REQ-041 dm_req held through its ack (new request, dm_addr=0x2004) -> second transaction starts the cycle after RESP; ram_addr=0x2004.

Source files
------------

// File: rtl/rapid_mem_arbiter.sv
// Shares one registered RAM port between instruction fetch (IF) and data memory (DM).
// Ties alternate between the two requesters; ack follows ram_ack by one cycle, or carries err after TIMEOUT busy cycles.
module rapid_mem_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_if_req,
    input  logic [XLEN-1:0] i_if_addr,
    output logic [XLEN-1:0] o_if_rdata,
    output logic            o_if_ack,
    input  logic            i_dm_req,
    input  logic            i_dm_we,
    input  logic [XLEN-1:0] i_dm_addr,
    input  logic [XLEN-1:0] i_dm_wdata,
    output logic [XLEN-1:0] o_dm_rdata,
    output logic            o_dm_ack,
    output logic            o_err,
    output logic            o_ram_req,
    output logic            o_ram_we,
    output logic [XLEN-1:0] o_ram_addr,
    output logic [XLEN-1:0] o_ram_wdata,
    input  logic [XLEN-1:0] i_ram_rdata,
    input  logic            i_ram_ack
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]      r_state;
    logic            r_owner;
    logic            r_last;
    logic [7:0]      r_cnt;
    logic            r_ram_req;
    logic            r_ram_we;
    logic [XLEN-1:0] r_ram_addr;
    logic [XLEN-1:0] r_ram_wdata;
    logic            r_if_ack;
    logic            r_dm_ack;
    logic            r_err;
    logic [XLEN-1:0] r_if_rdata;
    logic [XLEN-1:0] r_dm_rdata;

    logic            w_start;
    logic            w_grant_dm;
    logic            w_timeout;
    logic            w_done;
    logic [XLEN-1:0] w_resp_data;

    // On a tie, DM wins only if IF was the last one served.
    assign w_start     = i_if_req || i_dm_req;
    assign w_grant_dm  = i_dm_req && (!i_if_req || (r_last == OWN_IF));
    assign w_timeout   = (r_cnt == CNT_LAST);
    assign w_done      = i_ram_ack || w_timeout;
    assign w_resp_data = i_ram_ack ? i_ram_rdata : '0;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_owner     <= OWN_IF;
            r_last      <= OWN_IF;
            r_cnt       <= '0;
            r_ram_req   <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_dm_ack    <= 1'b0;
            r_err       <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state     <= S_BUSY;
                        r_owner     <= w_grant_dm;
                        r_cnt       <= '0;
                        r_ram_req   <= 1'b1;
                        r_ram_we    <= w_grant_dm && i_dm_we;
                        r_ram_addr  <= w_grant_dm ? i_dm_addr : i_if_addr;
                        r_ram_wdata <= w_grant_dm ? i_dm_wdata : '0;
                    end
                end
                S_BUSY: begin
                    if (w_done) begin
                        r_state   <= S_RESP;
                        r_ram_req <= 1'b0;
                        r_err     <= !i_ram_ack;
                        if (r_owner == OWN_DM) begin
                            r_dm_ack <= 1'b1;
                            // A completed store keeps the previous load data.
                            if (!(i_ram_ack && r_ram_we)) begin
                                r_dm_rdata <= w_resp_data;
                            end
                        end else begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= w_resp_data;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    r_last  <= r_owner;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_if_rdata  = r_if_rdata;
    assign o_if_ack    = r_if_ack;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_dm_ack    = r_dm_ack;
    assign o_err       = r_err;
    assign o_ram_req   = r_ram_req;
    assign o_ram_we    = r_ram_we;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_rapid_mem_arbiter.sv
// Bench for rapid_mem_arbiter: directed scenarios plus concurrent random IF/DM traffic,
// with a RAM model that queues expected responses and a separate ack monitor that checks them.
`timescale 1ns/1ps
module tb_rapid_mem_arbiter;

    localparam int XLEN = 32;
    localparam int TMO  = 4;

    logic            clk;
    logic            reset;
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic [XLEN-1:0] if_rdata;
    logic            if_ack;
    logic            dm_req;
    logic            dm_we;
    logic [XLEN-1:0] dm_addr;
    logic [XLEN-1:0] dm_wdata;
    logic [XLEN-1:0] dm_rdata;
    logic            dm_ack;
    logic            err;
    logic            ram_req;
    logic            ram_we;
    logic [XLEN-1:0] ram_addr;
    logic [XLEN-1:0] ram_wdata;
    logic [XLEN-1:0] ram_rdata;
    logic            ram_ack;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        bit          is_dm;
        bit          err;
        logic [31:0] rdata;
        bit          upd;
        int          cyc;
    } resp_t;

    resp_t       sb[$];
    logic [31:0] mem [logic [31:0]];
    bit          last_dm;
    int          force_delay;
    bit          spurious;

    rapid_mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_rdata  (if_rdata),
        .o_if_ack    (if_ack),
        .i_dm_req    (dm_req),
        .i_dm_we     (dm_we),
        .i_dm_addr   (dm_addr),
        .i_dm_wdata  (dm_wdata),
        .o_dm_rdata  (dm_rdata),
        .o_dm_ack    (dm_ack),
        .o_err       (err),
        .o_ram_req   (ram_req),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata),
        .i_ram_ack   (ram_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0F0F);
    endfunction

    // RAM model: checks each command, decides its latency and queues the expected response.
    initial begin : ram_side
        bit          active;
        bit          stable;
        bit          exp_dm;
        int          k;
        int          dly;
        logic        prev_if;
        logic        prev_dm;
        logic        c_we;
        logic [31:0] c_addr;
        logic [31:0] c_wdata;
        resp_t       e;
        ram_ack   = 1'b0;
        ram_rdata = '0;
        active    = 0;
        prev_if   = 1'b0;
        prev_dm   = 1'b0;
        k         = 0;
        dly       = 0;
        forever begin
            @(negedge clk);
            ram_ack = 1'b0;
            if (reset) begin
                active = 0;
            end else if (spurious) begin
                ram_ack   = 1'b1;
                ram_rdata = 32'hBAD0_BAD0;
                spurious  = 0;
            end else begin
                if (ram_req && !active) begin
                    active  = 1;
                    stable  = 1;
                    k       = 0;
                    c_we    = ram_we;
                    c_addr  = ram_addr;
                    c_wdata = ram_wdata;
                    check("grant_without_req", 32'(prev_if | prev_dm), 32'd1);
                    if (prev_dm && !prev_if)      exp_dm = 1;
                    else if (prev_if && !prev_dm) exp_dm = 0;
                    else                          exp_dm = !last_dm;
                    if (exp_dm) begin
                        check("cmd_dm_we", 32'(c_we), 32'(dm_we));
                        check("cmd_dm_addr", c_addr, dm_addr);
                        check("cmd_dm_wdata", c_wdata, dm_wdata);
                    end else begin
                        check("cmd_if_we", 32'(c_we), 32'd0);
                        check("cmd_if_addr", c_addr, if_addr);
                    end
                    if (force_delay >= 0)               dly = force_delay;
                    else if ($urandom_range(0, 9) < 8) dly = int'($urandom_range(0, 2));
                    else                                dly = int'($urandom_range(0, 6));
                end
                if (ram_req && active) begin
                    if (ram_we !== c_we || ram_addr !== c_addr || ram_wdata !== c_wdata) stable = 0;
                    if (k == dly) begin
                        ram_ack   = 1'b1;
                        ram_rdata = c_we ? $urandom : mem_rd(c_addr);
                        e.is_dm = exp_dm;
                        e.err   = 0;
                        e.rdata = c_we ? 32'h0 : mem_rd(c_addr);
                        e.upd   = !c_we;
                        e.cyc   = cyc + 1;
                        sb.push_back(e);
                        if (c_we) mem[c_addr] = c_wdata;
                    end else if (k == TMO - 1 && dly > k) begin
                        e.is_dm = exp_dm;
                        e.err   = 1;
                        e.rdata = 32'h0;
                        e.upd   = 1;
                        e.cyc   = cyc + 1;
                        sb.push_back(e);
                    end
                    k++;
                end else if (!ram_req && active) begin
                    check("ram_req_cycles", 32'(k), 32'((dly < TMO) ? dly + 1 : TMO));
                    check("ram_cmd_stable", 32'(stable), 32'd1);
                    active = 0;
                end
            end
            prev_if = if_req;
            prev_dm = dm_req;
        end
    end

    // Ack monitor: pops the scoreboard on every completion pulse.
    initial begin : ack_mon
        resp_t       e;
        logic [31:0] exp_if_rd;
        logic [31:0] exp_dm_rd;
        exp_if_rd = '0;
        exp_dm_rd = '0;
        forever begin
            @(negedge clk);
            if (if_ack || dm_ack) begin
                check("no_dual_ack", 32'(if_ack & dm_ack), 32'd0);
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ack: if_ack=%0b dm_ack=%0b with nothing outstanding (cycle %0d)",
                             if_ack, dm_ack, cyc);
                end else begin
                    e = sb.pop_front();
                    check("ack_owner_dm", 32'(dm_ack), 32'(e.is_dm));
                    check("ack_cycle", 32'(cyc), 32'(e.cyc));
                    check("ack_err", 32'(err), 32'(e.err));
                    if (e.upd) begin
                        if (e.is_dm) exp_dm_rd = e.rdata;
                        else         exp_if_rd = e.rdata;
                    end
                    check("if_rdata", if_rdata, exp_if_rd);
                    check("dm_rdata", dm_rdata, exp_dm_rd);
                    last_dm = e.is_dm;
                end
            end else if (err) begin
                n_tests++;
                n_fail++;
                $display("FAIL err_without_ack: err=1 with no ack (cycle %0d)", cyc);
            end
            if (reset) begin
                sb.delete();
                last_dm   = 0;
                exp_if_rd = '0;
                exp_dm_rd = '0;
            end
        end
    end

    task automatic if_xfer(input logic [31:0] a, output int s, output int c);
        @(posedge clk);
        #1;
        if_req  = 1'b1;
        if_addr = a;
        s = cyc;
        c = -1;
        for (int t = 0; t < 60 && c < 0; t++) begin
            @(negedge clk);
            if (if_ack) c = cyc;
        end
        if (c < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL if_ack_timeout: no if_ack for addr %h", a);
        end
    endtask

    task automatic dm_xfer(input logic we, input logic [31:0] a, input logic [31:0] d, output int c);
        @(posedge clk);
        #1;
        dm_req   = 1'b1;
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = d;
        c = -1;
        for (int t = 0; t < 60 && c < 0; t++) begin
            @(negedge clk);
            if (dm_ack) c = cyc;
        end
        if (c < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL dm_ack_timeout: no dm_ack for addr %h", a);
        end
    endtask

    task automatic if_idle(input int n);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic dm_idle(input int n);
        @(posedge clk);
        #1;
        dm_req = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int s;
        int c1;
        int c2;
        int c3;
        int c4;
        int got;
        reset       = 1'b1;
        if_req      = 1'b0;
        if_addr     = '0;
        dm_req      = 1'b0;
        dm_we       = 1'b0;
        dm_addr     = '0;
        dm_wdata    = '0;
        force_delay = -1;
        spurious    = 0;
        last_dm     = 0;
        mem[32'h100] = 32'h0000_0013;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ram_req", 32'(ram_req), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        check("rst_if_ack", 32'(if_ack), 32'd0);
        check("rst_dm_ack", 32'(dm_ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_dm_rdata", dm_rdata, 32'd0);

        // Single fetch, RAM answers in the first busy cycle.
        @(posedge clk);
        #1;
        reset       = 1'b0;
        force_delay = 0;
        if_xfer(32'h100, s, c1);
        check("fetch_latency", 32'(c1 - s), 32'd2);
        check("fetch_rdata", if_rdata, 32'h13);
        check("fetch_err", 32'(err), 32'd0);
        if_idle(2);

        // Both requesting straight out of reset: DM is served first.
        @(posedge clk);
        #1;
        reset       = 1'b1;
        force_delay = 1;
        repeat (2) @(posedge clk);
        fork
            begin dm_xfer(1'b1, 32'h2000, 32'hDEAD_BEEF, c1); check("tie_dm_rdata", dm_rdata, 32'd0); dm_idle(0); end
            begin if_xfer(32'h104, s, c2); if_idle(0); end
            begin @(posedge clk); #1; reset = 1'b0; end
        join
        check("tie_dm_first", 32'(c1 < c2), 32'd1);
        repeat (2) @(posedge clk);

        // Continuous requests from both: service alternates.
        force_delay = -1;
        fork
            begin dm_xfer(1'b0, 32'h2000, 32'h0, c1); dm_xfer(1'b1, 32'h2010, 32'h1234_5678, c3); dm_idle(0); end
            begin if_xfer(32'h108, s, c2); if_xfer(32'h2010, s, c4); if_idle(0); end
        join
        check("alt_order_1", 32'(c1 < c2), 32'd1);
        check("alt_order_2", 32'(c2 < c3), 32'd1);
        check("alt_order_3", 32'(c3 < c4), 32'd1);
        repeat (2) @(posedge clk);

        // RAM never answers a DM read; the following fetch completes cleanly.
        force_delay = 99;
        dm_xfer(1'b0, 32'h2008, 32'h0, c1);
        check("timeout_err", 32'(err), 32'd1);
        check("timeout_dm_rdata", dm_rdata, 32'd0);
        dm_idle(0);
        force_delay = 1;
        if_xfer(32'h100, s, c2);
        check("after_timeout_err", 32'(err), 32'd0);
        check("after_timeout_rdata", if_rdata, 32'h13);
        if_idle(1);

        // DM keeps req high through its ack with a new address.
        force_delay = 0;
        dm_xfer(1'b0, 32'h2000, 32'h0, c1);
        dm_xfer(1'b0, 32'h2004, 32'h0, c2);
        check("b2b_ack_spacing", 32'(c2 - c1), 32'd3);
        dm_idle(2);

        // Reset in the second busy cycle, then a stray ram_ack.
        force_delay = 99;
        @(posedge clk);
        #1;
        if_req  = 1'b1;
        if_addr = 32'h100;
        got = 0;
        for (int t = 0; t < 10 && got == 0; t++) begin
            @(negedge clk);
            if (ram_req) got = 1;
        end
        check("abort_saw_ram_req", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        if_req   = 1'b0;
        spurious = 1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            check("abort_ram_req", 32'(ram_req), 32'd0);
            check("abort_acks", 32'({if_ack, dm_ack}), 32'd0);
        end
        check("abort_ram_addr", ram_addr, 32'd0);
        check("abort_ram_we", 32'(ram_we), 32'd0);
        check("abort_if_rdata", if_rdata, 32'd0);
        check("abort_dm_rdata", dm_rdata, 32'd0);

        // Random concurrent traffic over a shared address window.
        force_delay = -1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if_xfer(32'h3000 + 32'(4 * $urandom_range(0, 7)), s, c1);
                    if ($urandom_range(0, 2) != 0) if_idle(int'($urandom_range(0, 3)));
                end
                if_idle(0);
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    dm_xfer(1'($urandom_range(0, 1)), 32'h3000 + 32'(4 * $urandom_range(0, 7)), $urandom, c2);
                    if ($urandom_range(0, 2) != 0) dm_idle(int'($urandom_range(0, 3)));
                end
                dm_idle(0);
            end
        join
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
